// File: rtl/interrupt_arbiter.sv
// Interrupt/trap arbiter: synchronizes NMI, tracks single-step TF, runs the INTA
// handshake with the interrupt controller and presents one vector to the sequencer.
module interrupt_arbiter #(
   parameter logic [7:0] NMI_VECTOR  = 8'h02,
   parameter logic [7:0] TRAP_VECTOR = 8'h01
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [15:0] flags_in,
   input  logic        nmi,
   input  logic        intr,
   input  logic        instr_boundary,
   input  logic        inhibit,
   input  logic [7:0]  pic_vector,
   input  logic        pic_vector_valid,
   output logic        inta,
   output logic        int_req,
   output logic [7:0]  int_vector,
   input  logic        int_ack
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PIC_ACK = 2'd1,
      REQ     = 2'd2
   } state_t;

   state_t     state_r, next_state_s;
   logic [7:0] next_vector_s;
   logic       take_nmi_s;
   logic       accept_s;
   logic       nmi_sync1_r, nmi_sync2_r, nmi_prev_r;
   logic       nmi_edge_s;
   logic       nmi_pending_r;
   logic       tf_armed_r;
   logic       unused_flags_s;

   assign unused_flags_s = ^{flags_in[15:10], flags_in[7:0]};
   assign nmi_edge_s     = nmi_sync2_r & ~nmi_prev_r;
   assign accept_s       = (state_r == REQ) & int_ack;

   // NMI synchronizer, edge history and pending flag (a new edge wins over the clear)
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         nmi_sync1_r   <= 1'b0;
         nmi_sync2_r   <= 1'b0;
         nmi_prev_r    <= 1'b0;
         nmi_pending_r <= 1'b0;
      end else begin
         nmi_sync1_r   <= nmi;
         nmi_sync2_r   <= nmi_sync1_r;
         nmi_prev_r    <= nmi_sync2_r;
         nmi_pending_r <= nmi_edge_s | (nmi_pending_r & ~take_nmi_s);
      end
   end

   // Single-step arming: sampled at boundaries seen in IDLE, cleared by handler entry
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tf_armed_r <= 1'b0;
      end else if (accept_s) begin
         tf_armed_r <= 1'b0;
      end else if ((state_r == IDLE) && instr_boundary) begin
         tf_armed_r <= flags_in[8];
      end else begin
         tf_armed_r <= tf_armed_r;
      end
   end

   // Next-state and vector selection
   always_comb begin
      next_state_s  = state_r;
      next_vector_s = int_vector;
      take_nmi_s    = 1'b0;
      case (state_r)
         IDLE: begin
            if (instr_boundary && !inhibit) begin
               if (nmi_pending_r) begin
                  take_nmi_s    = 1'b1;
                  next_vector_s = NMI_VECTOR;
                  next_state_s  = REQ;
               end else if (intr && flags_in[9]) begin
                  next_state_s = PIC_ACK;
               end else if (tf_armed_r) begin
                  next_vector_s = TRAP_VECTOR;
                  next_state_s  = REQ;
               end else begin
                  next_state_s = IDLE;
               end
            end else begin
               next_state_s = IDLE;
            end
         end
         PIC_ACK: begin
            if (pic_vector_valid) begin
               next_vector_s = pic_vector;
               next_state_s  = REQ;
            end else begin
               next_state_s = PIC_ACK;
            end
         end
         REQ: begin
            if (int_ack) begin
               next_state_s = IDLE;
            end else begin
               next_state_s = REQ;
            end
         end
         default: begin
            next_state_s = IDLE;
         end
      endcase
   end

   // State and registered outputs, decoded from the next state
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r    <= IDLE;
         inta       <= 1'b0;
         int_req    <= 1'b0;
         int_vector <= 8'h00;
      end else begin
         state_r    <= next_state_s;
         inta       <= (next_state_s == PIC_ACK);
         int_req    <= (next_state_s == REQ);
         int_vector <= next_vector_s;
      end
   end

endmodule

// File: tb/tb_interrupt_arbiter.sv
// Directed self-checking bench for interrupt_arbiter.
module tb_interrupt_arbiter;

   logic        clk;
   logic        reset_n;
   logic [15:0] flags_in;
   logic        nmi;
   logic        intr;
   logic        instr_boundary;
   logic        inhibit;
   logic [7:0]  pic_vector;
   logic        pic_vector_valid;
   logic        inta;
   logic        int_req;
   logic [7:0]  int_vector;
   logic        int_ack;

   int checks   = 0;
   int failures = 0;

   interrupt_arbiter dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .flags_in         (flags_in),
      .nmi              (nmi),
      .intr             (intr),
      .instr_boundary   (instr_boundary),
      .inhibit          (inhibit),
      .pic_vector       (pic_vector),
      .pic_vector_valid (pic_vector_valid),
      .inta             (inta),
      .int_req          (int_req),
      .int_vector       (int_vector),
      .int_ack          (int_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic boundary();
      instr_boundary = 1'b1;
      step();
      instr_boundary = 1'b0;
   endtask

   task automatic ack();
      int_ack = 1'b1;
      step();
      int_ack = 1'b0;
   endtask

   task automatic nmi_pulse();
      nmi = 1'b1;
      step();
      nmi = 1'b0;
      step();
   endtask

   initial begin
      reset_n = 1'b0; flags_in = 16'h0000; nmi = 1'b0; intr = 1'b0;
      instr_boundary = 1'b0; inhibit = 1'b0; pic_vector = 8'h00;
      pic_vector_valid = 1'b0; int_ack = 1'b0;
      step(); step();
      check("rst_inta", {7'd0, inta}, 8'h00);
      check("rst_req", {7'd0, int_req}, 8'h00);
      check("rst_vec", int_vector, 8'h00);
      reset_n = 1'b1;
      step();

      // NMI pulse, boundary several cycles later
      nmi_pulse();
      step(); step(); step();
      boundary();
      check("nmi_req", {7'd0, int_req}, 8'h01);
      check("nmi_vec", int_vector, 8'h02);
      check("nmi_inta", {7'd0, inta}, 8'h00);
      step();
      check("nmi_hold", {7'd0, int_req}, 8'h01);
      ack();
      check("nmi_ack", {7'd0, int_req}, 8'h00);
      boundary();
      check("nmi_once", {7'd0, int_req}, 8'h00);
      step();
      check("nmi_once2", {7'd0, int_req}, 8'h00);

      // INTR with IF=1, vector valid three cycles after the boundary
      intr = 1'b1; flags_in = 16'h0200;
      boundary();
      check("pic_inta1", {7'd0, inta}, 8'h01);
      step();
      check("pic_inta2", {7'd0, inta}, 8'h01);
      intr = 1'b0;
      step();
      check("pic_inta3", {7'd0, inta}, 8'h01);
      check("pic_noreq", {7'd0, int_req}, 8'h00);
      pic_vector = 8'h20; pic_vector_valid = 1'b1;
      step();
      pic_vector_valid = 1'b0; pic_vector = 8'h00;
      check("pic_inta_off", {7'd0, inta}, 8'h00);
      check("pic_req", {7'd0, int_req}, 8'h01);
      check("pic_vec", int_vector, 8'h20);
      step();
      check("pic_vec_hold", int_vector, 8'h20);
      ack();
      check("pic_ack", {7'd0, int_req}, 8'h00);

      // INTR masked by IF=0, then inhibited boundary with IF=1
      intr = 1'b1; flags_in = 16'h0000;
      boundary();
      check("mask_inta", {7'd0, inta}, 8'h00);
      check("mask_req", {7'd0, int_req}, 8'h00);
      flags_in = 16'h0200; inhibit = 1'b1;
      boundary();
      inhibit = 1'b0;
      check("inh_inta", {7'd0, inta}, 8'h00);
      check("inh_req", {7'd0, int_req}, 8'h00);
      intr = 1'b0; flags_in = 16'h0000;
      ack();
      check("stray_ack", {7'd0, int_req}, 8'h00);

      // Single-step trap taken one boundary late
      flags_in = 16'h0100;
      boundary();
      check("tf_not_k", {7'd0, int_req}, 8'h00);
      flags_in = 16'h0000;
      step(); step();
      boundary();
      check("tf_req", {7'd0, int_req}, 8'h01);
      check("tf_vec", int_vector, 8'h01);
      ack();
      check("tf_ack", {7'd0, int_req}, 8'h00);
      boundary();
      check("tf_once", {7'd0, int_req}, 8'h00);

      // Priority: NMI over INTR over armed trap; two NMI edges merge
      flags_in = 16'h0100;
      boundary();
      check("arm_noreq", {7'd0, int_req}, 8'h00);
      nmi_pulse();
      nmi_pulse();
      step(); step(); step();
      intr = 1'b1; flags_in = 16'h0200;
      boundary();
      check("pri_nmi_req", {7'd0, int_req}, 8'h01);
      check("pri_nmi_vec", int_vector, 8'h02);
      check("pri_nmi_inta", {7'd0, inta}, 8'h00);
      ack();
      boundary();
      check("pri_pic_inta", {7'd0, inta}, 8'h01);
      check("pri_pic_noreq", {7'd0, int_req}, 8'h00);
      pic_vector = 8'h33; pic_vector_valid = 1'b1;
      step();
      pic_vector_valid = 1'b0;
      check("pri_pic_vec", int_vector, 8'h33);
      check("pri_pic_req", {7'd0, int_req}, 8'h01);
      intr = 1'b0;
      ack();
      boundary();
      check("pri_merged", {7'd0, int_req}, 8'h00);
      check("pri_merged_inta", {7'd0, inta}, 8'h00);

      // Asynchronous reset in the middle of the INTA handshake
      intr = 1'b1; flags_in = 16'h0200;
      boundary();
      check("rst_mid_pre", {7'd0, inta}, 8'h01);
      #1;
      reset_n = 1'b0;
      #1;
      check("rst_mid_inta", {7'd0, inta}, 8'h00);
      check("rst_mid_req", {7'd0, int_req}, 8'h00);
      step();
      reset_n = 1'b1;
      intr = 1'b0; flags_in = 16'h0000;
      step();
      boundary();
      check("rst_post_req", {7'd0, int_req}, 8'h00);
      check("rst_post_inta", {7'd0, inta}, 8'h00);
      pic_vector = 8'h44; pic_vector_valid = 1'b1;
      step();
      pic_vector_valid = 1'b0;
      check("rst_post_req2", {7'd0, int_req}, 8'h00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
